// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Owns the single write port of the integer register file.
//   - After reset it zero-clears x1..x(2^AW-1), one register per cycle,
//     because the register array itself has no reset.
//   - It then arbitrates round-robin between two writeback requesters:
//     A (execute/ALU) and B (load unit).
//   - Writes are presented one cycle after the accepting edge on registered
//     outputs that drive the register file directly.
//   - Writes to x0 are accepted but never issued.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_a_valid    requester A has a write pending
//   i_a_addr     requester A destination register
//   i_a_data     requester A write data
//   o_a_ready    requester A accepted this cycle (combinational)
//   i_b_valid    requester B has a write pending
//   i_b_addr     requester B destination register
//   i_b_data     requester B write data
//   o_b_ready    requester B accepted this cycle (combinational)
//   o_write      register file write enable (registered)
//   o_waddr      register file write address (registered)
//   o_wdata      register file write data (registered)
//   o_init_done  high once the clear sequence has finished (registered)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int INIT_CLEAR = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_a_valid,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [XLEN-1:0] i_a_data,
  output logic            o_a_ready,
  input  logic            i_b_valid,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [XLEN-1:0] i_b_data,
  output logic            o_b_ready,
  output logic            o_write,
  output logic [AW-1:0]   o_waddr,
  output logic [XLEN-1:0] o_wdata,
  output logic            o_init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
  localparam logic   RESET_DONE  = (INIT_CLEAR == 0);

  state_t          state, state_next;
  logic [AW-1:0]   clr_cnt, clr_cnt_next;
  logic            last_b, last_b_next;
  logic            write_next;
  logic [AW-1:0]   waddr_next;
  logic [XLEN-1:0] wdata_next;
  logic            done_next;
  logic            grant_a, grant_b;

  // Round-robin: on a tie, last_b = 1 means B won last time, so A goes now.
  // The grant only depends on the valids and the pointer, never on the
  // write port, so a lone requester streams at one transfer per cycle.
  always_comb begin
    grant_a = i_a_valid && (!i_b_valid || last_b);
    grant_b = i_b_valid && (!i_a_valid || !last_b);
  end

  assign o_a_ready = (state == ST_RUN) && grant_a;
  assign o_b_ready = (state == ST_RUN) && grant_b;

  // State and output registers. The pointer starts as "last granted B" so
  // that A wins the first tie after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= RESET_STATE;
      clr_cnt     <= AW'(1);
      last_b      <= 1'b1;
      o_write     <= 1'b0;
      o_waddr     <= '0;
      o_wdata     <= '0;
      o_init_done <= RESET_DONE;
    end else begin
      state       <= state_next;
      clr_cnt     <= clr_cnt_next;
      last_b      <= last_b_next;
      o_write     <= write_next;
      o_waddr     <= waddr_next;
      o_wdata     <= wdata_next;
      o_init_done <= done_next;
    end
  end

  // Next-state and next-output logic. When nothing is written the address
  // and data registers hold, which includes an accepted write to x0: that
  // transfer moves the pointer but leaves the port idle.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    last_b_next  = last_b;
    write_next   = 1'b0;
    waddr_next   = o_waddr;
    wdata_next   = o_wdata;
    done_next    = o_init_done;

    case (state)
      ST_INIT: begin
        write_next   = 1'b1;
        waddr_next   = clr_cnt;
        wdata_next   = '0;
        clr_cnt_next = clr_cnt + 1'b1;
        // The edge issuing the highest register also ends the clear.
        if (clr_cnt == '1) begin
          state_next = ST_RUN;
          done_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (o_a_ready) begin
          last_b_next = 1'b0;
          if (i_a_addr != '0) begin
            write_next = 1'b1;
            waddr_next = i_a_addr;
            wdata_next = i_a_data;
          end
        end else if (o_b_ready) begin
          last_b_next = 1'b1;
          if (i_b_addr != '0) begin
            write_next = 1'b1;
            waddr_next = i_b_addr;
            wdata_next = i_b_data;
          end
        end
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 integer register file.
- After reset, it sequences a zero-clear of x1..x31, because the register array itself has no reset.
- It then arbitrates round-robin between two writeback requesters: A (execute/ALU) and B (load unit).
- Its registered outputs drive the register file's write address, write data and write enable directly.

Parameters:
- XLEN, 32, data width of write data.
- AW, 5, register address width; registers are numbered 0..2^AW-1.
- INIT_CLEAR, 1, 1 = run the zero-clear sequence after reset; 0 = enter RUN directly.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_a_valid  in  1  requester A has a write pending.
- i_a_addr  in  AW  requester A destination register.
- i_a_data  in  XLEN  requester A write data.
- o_a_ready  out  1  requester A accepted this cycle; combinational.
- i_b_valid  in  1  requester B has a write pending.
- i_b_addr  in  AW  requester B destination register.
- i_b_data  in  XLEN  requester B write data.
- o_b_ready  out  1  requester B accepted this cycle; combinational.
- o_write  out  1  register file write enable; registered.
- o_waddr  out  AW  register file write address; registered.
- o_wdata  out  XLEN  register file write data; registered.
- o_init_done  out  1  high once clearing is complete; registered.

Behaviour:
- Reset (asynchronous, any time, including mid-sequence or mid-handshake):
  - State = INIT (RUN if INIT_CLEAR=0), clear counter = 1, round-robin pointer = "last granted B".
  - o_write = 0, o_waddr = 0, o_wdata = 0, o_init_done = 0 (1 if INIT_CLEAR=0).
  - o_a_ready and o_b_ready evaluate to 0 while in INIT.
- INIT:
  - At each rising edge: o_write <= 1, o_waddr <= counter, o_wdata <= 0, counter increments.
  - The edge that issues address 31 also sets state <= RUN and o_init_done <= 1.
  - Exactly 31 write pulses occur, addresses 1..31 in order, on the first 31 edges after reset release.
  - No requester is accepted during INIT; valid requests are held off.
- RUN arbitration (combinational):
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester not granted most recently.
  - o_x_ready = (state == RUN) and grant to x. At most one ready is high per cycle.
- Handshake:
  - A transfer occurs when valid && ready.
  - A requester holds valid, addr and data stable until its transfer; deasserting valid before then is a protocol error and is undefined.
  - Ready never waits on anything other than arbitration, so a lone requester is accepted every cycle (full throughput).
- Latency:
  - A transfer at edge N is presented on o_write/o_waddr/o_wdata for the cycle following edge N: one-cycle registered latency.
  - With no transfer, o_write <= 0; o_waddr and o_wdata hold their previous values.
- Address 0:
  - The request is accepted (ready high) and the round-robin pointer updates, but o_write <= 0.
  - x0 is never written.
- Pointer update: the pointer updates only on a transfer.
- Same address from both requesters in consecutive grants: both writes issue in grant order, so the later-granted data is last in the register file. No merging.
- The block holds no write buffer; backpressure is purely the ready handshake.

Test Plan:
- Clear sequence: assert i_rst 3 cycles, release, hold both valids high -> o_write high for 31 consecutive cycles with o_waddr = 1..31 and o_wdata = 0; o_a_ready = o_b_ready = 0 throughout; o_init_done rises with the address-31 write; A is granted on the first RUN cycle.
- Single requester streaming: in RUN, A issues addr 5/6/7 with data 0x11/0x22/0x33 back-to-back -> ready high every cycle; o_write high for 3 cycles, each one cycle after its transfer, with matching addr/data.
- Contention: A and B both valid continuously (A: x3 = 0xAAAA0000, B: x4 = 0xBBBB0000) -> grants alternate A, B, A, B, starting with A after reset; o_waddr alternates 3, 4.
- x0 drop: B requests addr 0, data 0xDEADBEEF -> o_b_ready = 1 and o_write = 0 the next cycle; the pointer moves, so a subsequent tie is granted to A.
- Same-address race: A and B both target x9 (A = 0x1, B = 0x2) with the pointer favouring A -> o_write pulses at x9 with 0x1, then with 0x2; a register file model reads 0x2.
- Mid-clear reset: assert i_rst when o_waddr = 12 -> outputs go to 0 immediately (asynchronously); after release the sequence restarts at address 1 and completes all 31 writes.
